// File: rtl/pipe_skid_reg.sv
// Elastic two-entry pipeline register (main + skid) with valid/ready handshakes.
// in_ready_o comes straight from the state register, so no ready path crosses the stage.
`timescale 1ns/1ps
module pipe_skid_reg #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DWIDTH-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_data_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DWIDTH-1:0] r_main;
    logic [DWIDTH-1:0] r_skid;
    logic [DWIDTH-1:0] w_main_nxt;
    logic [DWIDTH-1:0] w_skid_nxt;
    logic              w_acc;
    logic              w_fire;

    assign out_valid_o = (r_state != ST_EMPTY);
    assign in_ready_o  = (r_state != ST_FULL) && !rst;
    assign out_data_o  = r_main;
    assign w_acc       = in_valid_i && in_ready_o;
    assign w_fire      = out_valid_o && out_ready_i;

    // Next-state and storage update; flush discards everything, including a same-cycle accept.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = {DWIDTH{1'b0}};
            w_skid_nxt  = {DWIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data_i;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data_i;
                    end else if (w_acc) begin
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = in_data_i;
                    end else if (w_fire) begin
                        // main keeps its stale word; consumers ignore it while invalid
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = {DWIDTH{1'b0}};
                    w_skid_nxt  = {DWIDTH{1'b0}};
                end
            endcase
        end
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= {DWIDTH{1'b0}};
            r_skid  <= {DWIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: per-scenario step tables plus a FIFO scoreboard
// filled on every accept and drained on every fire.
`timescale 1ns/1ps
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;

    int          vectors;
    int          miscompares;
    logic [31:0] sb [$];
    logic [31:0] exp_w;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        f;
        logic        eir;
        logic        eov;
        logic        chkd;
        logic [31:0] eod;
    } step_t;

    pipe_skid_reg #(.DWIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t stp(input logic v, input logic [31:0] d, input logic r, input logic f,
                                  input logic eir, input logic eov, input logic chkd, input logic [31:0] eod);
        step_t s;
        s.v = v; s.d = d; s.r = r; s.f = f; s.eir = eir; s.eov = eov; s.chkd = chkd; s.eod = eod;
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hDEADBEEF; out_ready_i = 1'b0;
        #1;
        vectors++;
        if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready_during got %b want 0", in_ready_o); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid cyc %0d got %b want 0", i, out_valid_o); end
            vectors++;
            if (out_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_out_data cyc %0d got %h want 0", i, out_data_o); end
            vectors++;
            if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready cyc %0d got %b want 0", i, in_ready_o); end
        end
        rst = 1'b0; in_valid_i = 1'b0;
        #1;
        vectors++;
        if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_after got %b want 1", in_ready_o); end
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_nothing_captured got %b want 0", out_valid_o); end
    endtask

    task automatic test_streaming();
        step_t t [5];
        t[0] = stp(1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        t[1] = stp(1'b1, 32'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1);
        t[2] = stp(1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2);
        t[3] = stp(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3);
        t[4] = stp(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            in_valid_i = t[i].v; in_data_i = t[i].d; out_ready_i = t[i].r; flush_i = t[i].f;
            #1;
            vectors++;
            if (in_ready_o !== t[i].eir) begin miscompares++; $display("FAIL stream_in_ready step %0d got %b want %b", i, in_ready_o, t[i].eir); end
            vectors++;
            if (out_valid_o !== t[i].eov) begin miscompares++; $display("FAIL stream_out_valid step %0d got %b want %b", i, out_valid_o, t[i].eov); end
            if (t[i].chkd) begin
                vectors++;
                if (out_data_o !== t[i].eod) begin miscompares++; $display("FAIL stream_out_data step %0d got %h want %h", i, out_data_o, t[i].eod); end
            end
            if (out_valid_o && out_ready_i) begin
                vectors++;
                if (sb.size() == 0) begin miscompares++; $display("FAIL stream_sb_extra step %0d got %h want none", i, out_data_o); end
                else begin
                    exp_w = sb.pop_front();
                    if (out_data_o !== exp_w) begin miscompares++; $display("FAIL stream_sb_order step %0d got %h want %h", i, out_data_o, exp_w); end
                end
            end
            if (flush_i) sb.delete();
            else if (in_valid_i && in_ready_o) sb.push_back(in_data_i);
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        step_t t [8];
        t[0] = stp(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        t[1] = stp(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA);
        t[2] = stp(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA);
        t[3] = stp(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA);
        t[4] = stp(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA);
        t[5] = stp(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB);
        t[6] = stp(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hC);
        t[7] = stp(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            in_valid_i = t[i].v; in_data_i = t[i].d; out_ready_i = t[i].r; flush_i = t[i].f;
            #1;
            vectors++;
            if (in_ready_o !== t[i].eir) begin miscompares++; $display("FAIL bp_in_ready step %0d got %b want %b", i, in_ready_o, t[i].eir); end
            vectors++;
            if (out_valid_o !== t[i].eov) begin miscompares++; $display("FAIL bp_out_valid step %0d got %b want %b", i, out_valid_o, t[i].eov); end
            if (t[i].chkd) begin
                vectors++;
                if (out_data_o !== t[i].eod) begin miscompares++; $display("FAIL bp_out_data step %0d got %h want %h", i, out_data_o, t[i].eod); end
            end
            if (out_valid_o && out_ready_i) begin
                vectors++;
                if (sb.size() == 0) begin miscompares++; $display("FAIL bp_sb_extra step %0d got %h want none", i, out_data_o); end
                else begin
                    exp_w = sb.pop_front();
                    if (out_data_o !== exp_w) begin miscompares++; $display("FAIL bp_sb_order step %0d got %h want %h", i, out_data_o, exp_w); end
                end
            end
            if (flush_i) sb.delete();
            else if (in_valid_i && in_ready_o) sb.push_back(in_data_i);
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_drain_and_acc_fire();
        step_t t [8];
        t[0] = stp(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        t[1] = stp(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55);
        t[2] = stp(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        t[3] = stp(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        t[4] = stp(1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10);
        t[5] = stp(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20);
        t[6] = stp(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20);
        t[7] = stp(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            in_valid_i = t[i].v; in_data_i = t[i].d; out_ready_i = t[i].r; flush_i = t[i].f;
            #1;
            vectors++;
            if (in_ready_o !== t[i].eir) begin miscompares++; $display("FAIL accfire_in_ready step %0d got %b want %b", i, in_ready_o, t[i].eir); end
            vectors++;
            if (out_valid_o !== t[i].eov) begin miscompares++; $display("FAIL accfire_out_valid step %0d got %b want %b", i, out_valid_o, t[i].eov); end
            if (t[i].chkd) begin
                vectors++;
                if (out_data_o !== t[i].eod) begin miscompares++; $display("FAIL accfire_out_data step %0d got %h want %h", i, out_data_o, t[i].eod); end
            end
            if (out_valid_o && out_ready_i) begin
                vectors++;
                if (sb.size() == 0) begin miscompares++; $display("FAIL accfire_sb_extra step %0d got %h want none", i, out_data_o); end
                else begin
                    exp_w = sb.pop_front();
                    if (out_data_o !== exp_w) begin miscompares++; $display("FAIL accfire_sb_order step %0d got %h want %h", i, out_data_o, exp_w); end
                end
            end
            if (flush_i) sb.delete();
            else if (in_valid_i && in_ready_o) sb.push_back(in_data_i);
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_flush();
        step_t t [8];
        t[0] = stp(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        t[1] = stp(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA);
        t[2] = stp(1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA);
        t[3] = stp(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        t[4] = stp(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        t[5] = stp(1'b1, 32'hD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        t[6] = stp(1'b1, 32'hE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hD);
        t[7] = stp(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 8; i++) begin
            in_valid_i = t[i].v; in_data_i = t[i].d; out_ready_i = t[i].r; flush_i = t[i].f;
            #1;
            vectors++;
            if (in_ready_o !== t[i].eir) begin miscompares++; $display("FAIL flush_in_ready step %0d got %b want %b", i, in_ready_o, t[i].eir); end
            vectors++;
            if (out_valid_o !== t[i].eov) begin miscompares++; $display("FAIL flush_out_valid step %0d got %b want %b", i, out_valid_o, t[i].eov); end
            if (t[i].chkd) begin
                vectors++;
                if (out_data_o !== t[i].eod) begin miscompares++; $display("FAIL flush_out_data step %0d got %h want %h", i, out_data_o, t[i].eod); end
            end
            if (out_valid_o && out_ready_i) begin
                vectors++;
                if (sb.size() == 0) begin miscompares++; $display("FAIL flush_sb_extra step %0d got %h want none", i, out_data_o); end
                else begin
                    exp_w = sb.pop_front();
                    if (out_data_o !== exp_w) begin miscompares++; $display("FAIL flush_sb_order step %0d got %h want %h", i, out_data_o, exp_w); end
                end
            end
            if (flush_i) sb.delete();
            else if (in_valid_i && in_ready_o) sb.push_back(in_data_i);
            @(posedge clk); @(negedge clk);
        end
        flush_i = 1'b0;
    endtask

    task automatic test_reset_midstream();
        in_valid_i = 1'b1; in_data_i = 32'h77; out_ready_i = 1'b0; flush_i = 1'b0;
        @(posedge clk); @(negedge clk);
        in_data_i = 32'h88;
        @(posedge clk); @(negedge clk);
        vectors++;
        if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL midrst_full got %b want 0", in_ready_o); end
        rst = 1'b1; in_valid_i = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; out_ready_i = 1'b1;
        #1;
        vectors++;
        if (out_valid_o !== 1'b0 || out_data_o !== 32'h0) begin
            miscompares++; $display("FAIL midrst_discard got v=%b d=%h want v=0 d=0", out_valid_o, out_data_o);
        end
        vectors++;
        if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got %b want 1", in_ready_o); end
        sb.delete();
        @(posedge clk); @(negedge clk);
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_stays_empty got %b want 0", out_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic        prev_stall;
        logic [31:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 32'h0;
        for (int i = 0; i < 400; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_data_i   = $urandom;
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 49) == 0);
            if (i >= 390) begin
                in_valid_i = 1'b0; out_ready_i = 1'b1; flush_i = 1'b0;
            end
            #1;
            if (prev_stall) begin
                vectors++;
                if (out_valid_o !== 1'b1 || out_data_o !== prev_data) begin
                    miscompares++; $display("FAIL b2b_stable cyc %0d got v=%b d=%h want v=1 d=%h", i, out_valid_o, out_data_o, prev_data);
                end
            end
            if (out_valid_o && out_ready_i) begin
                vectors++;
                if (sb.size() == 0) begin miscompares++; $display("FAIL b2b_sb_extra cyc %0d got %h want none", i, out_data_o); end
                else begin
                    exp_w = sb.pop_front();
                    if (out_data_o !== exp_w) begin miscompares++; $display("FAIL b2b_sb_order cyc %0d got %h want %h", i, out_data_o, exp_w); end
                end
            end
            if (flush_i) sb.delete();
            else if (in_valid_i && in_ready_o) sb.push_back(in_data_i);
            prev_stall = out_valid_o && !out_ready_i && !flush_i;
            prev_data  = out_data_o;
            @(posedge clk); @(negedge clk);
        end
        vectors++;
        if (sb.size() != 0 || out_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL b2b_drained got left=%0d v=%b want left=0 v=0", sb.size(), out_valid_o);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_drain_and_acc_fire();
        test_flush();
        test_reset_midstream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline register: the downstream-facing counterpart of the plain sync-reset data register.
- Accepts DWIDTH words from a producer over a valid/ready handshake and presents them to a consumer that may apply backpressure.
- Two-entry storage (main + skid) gives full throughput with in_ready_o fully registered, so no combinational ready path crosses the stage.
- Used between pipeline stages (fetch/decode and later) that need stall and flush.

Parameters:
- DWIDTH, 32, width of the data word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous flush; discards all held entries.
- in_valid_i  input  1  producer has a word on in_data_i.
- in_ready_o  output  1  stage can accept a word this cycle.
- in_data_i  input  DWIDTH  producer data.
- out_valid_o  output  1  out_data_o holds a valid word.
- out_ready_i  input  1  consumer accepts the word this cycle.
- out_data_o  output  DWIDTH  data presented to the consumer.

Behaviour:
- Handshake events:
  - Input accept (acc) = in_valid_i && in_ready_o.
  - Output fire (fire) = out_valid_o && out_ready_i.
- State machine:
  - States: EMPTY (0 held), ONE (main valid), FULL (main + skid valid).
  - Registers: main_q and skid_q, each DWIDTH.
- Outputs are a pure function of registered state:
  - out_valid_o = (state != EMPTY).
  - in_ready_o = (state != FULL) && !rst.
  - out_data_o = main_q.
- Transitions (rst and flush_i both low):
  - EMPTY: acc -> ONE, main_q <= in_data_i.
  - ONE: acc && fire -> ONE, main_q <= in_data_i.
  - ONE: acc && !fire -> FULL, skid_q <= in_data_i.
  - ONE: !acc && fire -> EMPTY, main_q holds its stale value.
  - ONE: neither -> hold.
  - FULL: fire -> ONE, main_q <= skid_q. No acc is possible because in_ready_o = 0.
  - FULL: !fire -> hold; main_q and out_data_o stay stable.
- Latency: a word accepted at edge N is visible on out_data_o/out_valid_o after edge N (1 cycle).
- Throughput: sustained 1 word/cycle when out_ready_i stays high.
- Ordering: strict FIFO order; no word is dropped or duplicated outside flush/reset.
- Stability: while out_valid_o && !out_ready_i, out_data_o and out_valid_o must not change.
- Reset (highest priority):
  - Next state EMPTY; main_q, skid_q <= 0.
  - After reset: out_valid_o = 0, out_data_o = 0, in_ready_o = 1.
  - in_ready_o = 0 while rst is high.
  - A reset mid-transfer discards all held words.
- Flush (below rst, above everything else):
  - Next state EMPTY; main_q, skid_q <= 0.
  - A word accepted in the flush cycle is discarded.
  - A fire in the flush cycle counts as delivered to the consumer.
- The stale main_q left after draining to EMPTY is don't-care to consumers; it is zeroed only by reset or flush.

Test Plan:
- Reset: assert rst 2 cycles with in_valid_i = 1, in_data_i = 0xDEADBEEF -> out_valid_o = 0, out_data_o = 0, in_ready_o = 0 during rst, in_ready_o = 1 after; nothing captured.
- Streaming: out_ready_i = 1, push 0x1, 0x2, 0x3 on consecutive cycles -> out_data_o 0x1, 0x2, 0x3 on the next three cycles; in_ready_o stays 1 throughout.
- Backpressure: out_ready_i = 0, push 0xA then 0xB:
  - in_ready_o drops to 0 after the second accept; 0xC is held off.
  - out_data_o stays 0xA.
  - Raise out_ready_i -> outputs 0xA, 0xB, 0xC in order; no loss.
- Drain: push 0x55 into EMPTY, fire next cycle with no new input -> state EMPTY, out_valid_o = 0.
- Flush while FULL (0xA, 0xB) with in_valid_i = 1, data 0xC -> next cycle out_valid_o = 0, out_data_o = 0, in_ready_o = 1; 0xA, 0xB and 0xC never appear.
- Simultaneous acc and fire in ONE: holding 0x10, push 0x20 while out_ready_i = 1 -> next cycle out_data_o = 0x20, state ONE, in_ready_o = 1.
